// File: rtl/johnson_slot_scheduler.sv
// rtl/johnson_slot_scheduler.sv - time-division arbiter sequenced by an N-bit Johnson counter
// Each Johnson state is a slot owned by one requester; a grant is held until done, request drop or timeout.
module johnson_slot_scheduler #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [2*N-1:0]          req,
  input  logic                    done,
  output logic [2*N-1:0]          gnt,
  output logic                    busy,
  output logic [N-1:0]            slot,
  output logic [$clog2(2*N)-1:0]  slot_idx,
  output logic                    timeout
);

  localparam int SW     = $clog2(2*N);
  localparam int HW_RAW = $clog2(HOLD_MAX + 1);
  localparam int HW     = (HW_RAW < 1) ? 1 : HW_RAW;

  typedef enum logic {SCAN, GRANT} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    slot_d;
  logic [2*N-1:0]  gnt_d;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic            timeout_d;

  int              ones_cnt;
  logic [N-1:0]    code_from_idx;
  logic            slot_valid;
  logic [N-1:0]    slot_step;
  logic            req_cur;
  logic            tmo_hit;
  logic            release_now;

  always_comb begin
    ones_cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (slot[i]) ones_cnt = ones_cnt + 1;
    end
  end

  assign slot_idx = slot[N-1] ? SW'(2*N - ones_cnt) : SW'(ones_cnt);

  // Rebuild the legal code for the decoded index; any other pattern is a corrupted counter.
  always_comb begin
    code_from_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(slot_idx) <= N) code_from_idx[i] = (i < int'(slot_idx));
      else                     code_from_idx[i] = (i >= int'(slot_idx) - N);
    end
  end

  assign slot_valid  = (slot == code_from_idx);
  assign slot_step   = {slot[N-2:0], ~slot[N-1]};
  assign req_cur     = req[slot_idx];
  assign tmo_hit     = (HOLD_MAX > 0) && (hold_cnt == HW'(HOLD_MAX - 1));
  assign release_now = done || !req_cur || tmo_hit;
  assign busy        = (state_q == GRANT);

  always_comb begin
    state_d   = state_q;
    slot_d    = slot;
    gnt_d     = gnt;
    hold_d    = hold_cnt;
    timeout_d = 1'b0;
    if (!slot_valid) begin
      state_d = SCAN;
      slot_d  = '0;
      gnt_d   = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        SCAN: begin
          if (en) begin
            if (req_cur) begin
              state_d = GRANT;
              gnt_d   = (2*N)'(1) << slot_idx;
              hold_d  = '0;
            end else begin
              slot_d = slot_step;
            end
          end
        end
        GRANT: begin
          hold_d = hold_cnt + HW'(1);
          if (release_now) begin
            state_d   = SCAN;
            slot_d    = slot_step;
            gnt_d     = '0;
            hold_d    = '0;
            // A release that done or a dropped request also explains is not a timeout.
            timeout_d = tmo_hit && !done && req_cur;
          end
        end
        default: begin
          state_d = SCAN;
          gnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SCAN;
      slot     <= '0;
      gnt      <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot     <= slot_d;
      gnt      <= gnt_d;
      hold_cnt <= hold_d;
      timeout  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_johnson_slot_scheduler.sv
// tb/tb_johnson_slot_scheduler.sv - bench for johnson_slot_scheduler (N=4, HOLD_MAX=8)
// Per-cycle vectors with hand-derived expectations, queued as a scoreboard and checked after each edge.
module tb_johnson_slot_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic       busy;
  logic [3:0] slot;
  logic [2:0] slot_idx;
  logic       timeout;

  johnson_slot_scheduler #(.N(4), .HOLD_MAX(8)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt(gnt), .busy(busy), .slot(slot), .slot_idx(slot_idx), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       busy;
    logic [2:0] idx;
    logic       to;
  } vec_t;

  typedef struct {
    logic [7:0] gnt;
    logic       busy;
    logic [2:0] idx;
    logic       to;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  logic [3:0] jcode [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};
  int checks = 0;
  int errors = 0;

  function automatic void add(input logic r, input logic e, input logic [7:0] q, input logic d,
                              input logic [7:0] g, input logic b, input int i, input logic t);
    vec_t v;
    v.rst = r; v.en = e; v.req = q; v.done = d;
    v.gnt = g; v.busy = b; v.idx = 3'(i); v.to = t;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, req_v);
    end
  endtask

  initial begin
    // idle scan from reset, full period
    add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 1, 8'h00, 0, 8'h00, 0, k % 8, 0);
    // req[3] held, done two cycles into the grant
    add(0, 1, 8'h08, 0, 8'h00, 0, 1, 0);
    add(0, 1, 8'h08, 0, 8'h00, 0, 2, 0);
    add(0, 1, 8'h08, 0, 8'h00, 0, 3, 0);
    add(0, 1, 8'h08, 0, 8'h08, 1, 3, 0);
    add(0, 1, 8'h08, 0, 8'h08, 1, 3, 0);
    add(0, 1, 8'h08, 1, 8'h00, 0, 4, 0);
    // all requesting, done always high: grants rotate with one scan cycle between
    add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    for (int k = 0; k <= 8; k++) begin
      add(0, 1, 8'hFF, 1, 8'(1 << (k % 8)), 1, k % 8, 0);
      add(0, 1, 8'hFF, 1, 8'h00, 0, (k + 1) % 8, 0);
    end
    // req[5] never released: 8-cycle grant then timeout pulse
    add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 1, 8'h20, 0, 8'h00, 0, k, 0);
    for (int k = 0; k < 8; k++) add(0, 1, 8'h20, 0, 8'h20, 1, 5, 0);
    add(0, 1, 8'h20, 0, 8'h00, 0, 6, 1);
    add(0, 1, 8'h00, 0, 8'h00, 0, 7, 0);
    // done coinciding with the timeout edge is a normal release
    add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    for (int k = 0; k < 8; k++) add(0, 1, 8'h01, 0, 8'h01, 1, 0, 0);
    add(0, 1, 8'h01, 1, 8'h00, 0, 1, 0);
    // reset in the middle of a slot-2 grant, done in the same cycle
    add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'h04, 0, 8'h00, 0, 1, 0);
    add(0, 1, 8'h04, 0, 8'h00, 0, 2, 0);
    add(0, 1, 8'h04, 0, 8'h04, 1, 2, 0);
    add(1, 1, 8'h04, 1, 8'h00, 0, 0, 0);
    add(0, 1, 8'h00, 0, 8'h00, 0, 1, 0);
    // request drop releases without timeout; en=0 freezes scan at slot 6
    add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'h02, 0, 8'h00, 0, 1, 0);
    add(0, 1, 8'h02, 0, 8'h02, 1, 1, 0);
    add(0, 1, 8'h00, 0, 8'h00, 0, 2, 0);
    for (int k = 3; k <= 6; k++) add(0, 1, 8'h00, 0, 8'h00, 0, k, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 8'h40, 0, 8'h00, 0, 6, 0);
    add(0, 1, 8'h40, 0, 8'h40, 1, 6, 0);
    add(0, 0, 8'h40, 0, 8'h40, 1, 6, 0);
    add(0, 0, 8'h40, 1, 8'h00, 0, 7, 0);

    for (int s = 0; s < vecs.size(); s++) begin
      exp_t e;
      @(negedge clk);
      rst  = vecs[s].rst;
      en   = vecs[s].en;
      req  = vecs[s].req;
      done = vecs[s].done;
      e.gnt = vecs[s].gnt; e.busy = vecs[s].busy; e.idx = vecs[s].idx; e.to = vecs[s].to;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard step %0d: queue empty", s);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("gnt", s, gnt, x.gnt);
        chk("busy", s, {7'b0, busy}, {7'b0, x.busy});
        chk("slot_idx", s, {5'b0, slot_idx}, {5'b0, x.idx});
        chk("slot", s, {4'b0, slot}, {4'b0, jcode[x.idx]});
        chk("timeout", s, {7'b0, timeout}, {7'b0, x.to});
        chk("gnt_onehot0", s, {7'b0, $onehot0(gnt)}, 8'h01);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
